// File: rtl/score_accumulator_if.sv
// rtl/score_accumulator_if.sv - game control and score stream bundle for score_accumulator
interface score_accumulator_if #(
   parameter int WIDTH  = 8,
   parameter int ROUNDS = 8
);
   localparam int CW = $clog2(ROUNDS + 1);

   logic             start;
   logic             score_valid;
   logic [WIDTH-1:0] score_in;
   logic             score_ready;
   logic [WIDTH-1:0] total;
   logic [CW-1:0]    round_cnt;
   logic             overflow;
   logic             busy;
   logic             done;

   modport master (
      output start, score_valid, score_in,
      input  score_ready, total, round_cnt, overflow, busy, done
   );

   modport slave (
      input  start, score_valid, score_in,
      output score_ready, total, round_cnt, overflow, busy, done
   );
endinterface

// File: rtl/score_accumulator.sv
// rtl/score_accumulator.sv - per-game score accumulator with ripple-carry adder and sticky overflow
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module score_accumulator #(
   parameter int WIDTH  = 8,
   parameter int ROUNDS = 8,
   parameter int SAT    = 1
) (
   input logic                clk,
   input logic                rst,
   score_accumulator_if.slave bus
);
   localparam int            CW   = $clog2(ROUNDS + 1);
   localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] total_q, total_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] reduced;
   logic             accept;

   assign carry[0] = 1'b0;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_rca
         full_adder u_fa (
            .a    (total_q[i]),
            .b    (bus.score_in[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
         );
      end
   endgenerate

   // Saturating mode pins the total at all-ones whenever the chain carries out.
   assign reduced = ((SAT != 0) && carry[WIDTH]) ? {WIDTH{1'b1}} : sum;
   assign accept  = bus.score_valid && (state == ACCUM);

   always_comb begin
      state_d = state;
      total_d = total_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = ACCUM;
               total_d = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         ACCUM: begin
            // A restart wins over a score presented on the same cycle.
            if (bus.start) begin
               total_d = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end else if (accept) begin
               total_d = reduced;
               cnt_d   = cnt_q + 1'b1;
               ovf_d   = ovf_q | carry[WIDTH];
               if (cnt_q == LAST) begin
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         total_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state   <= state_d;
         total_q <= total_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.score_ready = (state == ACCUM);
   assign bus.busy        = (state == ACCUM);
   assign bus.done        = (state == DONE);
   assign bus.total       = total_q;
   assign bus.round_cnt   = cnt_q;
   assign bus.overflow    = ovf_q;
endmodule
